// File: rtl/spi_slave.sv
// SPI responder: oversampled SCLK/SS_N/MOSI, one byte per slot, full duplex, all CPOL/CPHA modes.
// Define SPI_SLAVE_LSB_FIRST_EN for LSB-first shifting in both directions (default MSB-first).
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cpol_i,
  input  logic       cpha_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o,
  output logic       spi_done_tick_o,
  output logic       busy_o,
  input  logic       sclk_i,
  input  logic       ss_n_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe_o
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_prev, ss_prev;
  logic                   lead_q, trail_q, ss_fall_q, ss_rise_q, mosi_q;
  logic [1:0]             fill_cnt;
  logic                   armed;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx_q, tx_q, rx_next;
  logic                   sample_edge, shift_edge;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  function automatic logic out_bit(input logic [7:0] b);
    return b[0];
  endfunction
  function automatic logic [7:0] shift_out(input logic [7:0] b);
    return {1'b0, b[7:1]};
  endfunction
  assign rx_next = {mosi_q, rx_q[7:1]};
`else
  function automatic logic out_bit(input logic [7:0] b);
    return b[7];
  endfunction
  function automatic logic [7:0] shift_out(input logic [7:0] b);
    return {b[6:0], 1'b0};
  endfunction
  assign rx_next = {rx_q[6:0], mosi_q};
`endif

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign ss_s        = ss_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign sample_edge = cpha_i ? trail_q : lead_q;
  assign shift_edge  = cpha_i ? lead_q : trail_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync <= {SYNC_STAGES{cpol_i}};
      ss_sync   <= '1;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
    end
  end

  // Select falls are only accepted once a real (not preloaded) high level has
  // been seen, so SS_N held low across reset release cannot start a frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_prev <= cpol_i;
      ss_prev   <= 1'b1;
      lead_q    <= 1'b0;
      trail_q   <= 1'b0;
      ss_fall_q <= 1'b0;
      ss_rise_q <= 1'b0;
      mosi_q    <= 1'b0;
      fill_cnt  <= '0;
      armed     <= 1'b0;
    end else begin
      sclk_prev <= sclk_s;
      ss_prev   <= ss_s;
      mosi_q    <= mosi_s;
      lead_q    <= (sclk_s != sclk_prev) && (sclk_prev == cpol_i);
      trail_q   <= (sclk_s != sclk_prev) && (sclk_s == cpol_i);
      ss_fall_q <= armed && ss_prev && !ss_s;
      ss_rise_q <= !ss_prev && ss_s;
      if (fill_cnt != 2'(SYNC_STAGES)) fill_cnt <= fill_cnt + 2'd1;
      else if (ss_s)                   armed    <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      rx_q            <= '0;
      tx_q            <= '0;
      dout_o          <= '0;
      spi_done_tick_o <= 1'b0;
      busy_o          <= 1'b0;
      miso_o          <= 1'b0;
      miso_oe_o       <= 1'b0;
    end else begin
      spi_done_tick_o <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall_q) begin
            state     <= ACTIVE;
            busy_o    <= 1'b1;
            miso_oe_o <= 1'b1;
            bit_cnt   <= '0;
            if (!cpha_i) begin
              miso_o <= out_bit(din_i);
              tx_q   <= shift_out(din_i);
            end else begin
              tx_q   <= din_i;
            end
          end
        end
        ACTIVE: begin
          if (ss_rise_q) begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            miso_oe_o <= 1'b0;
            bit_cnt   <= '0;
          end else begin
            if (sample_edge) begin
              rx_q    <= rx_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                dout_o          <= rx_next;
                spi_done_tick_o <= 1'b1;
              end
            end
            // A shift edge with the counter at zero is a byte boundary:
            // the next byte is taken from din_i, which the host may have
            // updated after the done tick.
            if (shift_edge) begin
              if (bit_cnt == 3'd0) begin
                miso_o <= out_bit(din_i);
                tx_q   <= shift_out(din_i);
              end else begin
                miso_o <= out_bit(tx_q);
                tx_q   <= shift_out(tx_q);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: bit-level SPI master model, scoreboard on the done tick, random frames.
module tb_spi_slave;

  localparam int H = 8;  // SCLK half period in clk cycles

  logic       clk = 1'b0;
  logic       rst_i, cpol_i, cpha_i;
  logic [7:0] din_i, dout_o;
  logic       spi_done_tick_o, busy_o;
  logic       sclk_i, ss_n_i, mosi_i, miso_o, miso_oe_o;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_dout;
  logic [7:0] m_tx[4];
  logic [7:0] s_din[4];

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .cpol_i(cpol_i), .cpha_i(cpha_i),
    .din_i(din_i), .dout_o(dout_o), .spi_done_tick_o(spi_done_tick_o),
    .busy_o(busy_o), .sclk_i(sclk_i), .ss_n_i(ss_n_i), .mosi_i(mosi_i),
    .miso_o(miso_o), .miso_oe_o(miso_oe_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // bit order seen on the wire
  function automatic logic wire_bit(input logic [7:0] b, input int i);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return b[i];
`else
    return b[7-i];
`endif
  endfunction

  function automatic logic [7:0] wire_acc(input logic [7:0] r, input logic m);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return {m, r[7:1]};
`else
    return {r[6:0], m};
`endif
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (spi_done_tick_o) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_tick: got dout 0x%0h expected no tick", dout_o);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (dout_o !== e) begin
          n_fail++;
          $display("FAIL dout: got 0x%0h expected 0x%0h", dout_o, e);
        end
      end
    end
  end

  // Master driver. stop_bits != 0 ends the frame early after that many bits,
  // either by raising ss_n (use_reset=0) or by resetting the DUT (use_reset=1).
  task automatic frame(input logic pol, input logic pha, input int nbytes,
                       input int stop_bits, input bit use_reset);
    logic [7:0] rxm;
    int         bits;
    bits   = 0;
    cpol_i = pol;
    cpha_i = pha;
    sclk_i = pol;
    din_i  = s_din[0];
    wait_clk(H);
    ss_n_i = 1'b0;
    wait_clk(H);
    for (int b = 0; b < nbytes; b++) begin
      rxm = '0;
      for (int i = 0; i < 8; i++) begin
        if (stop_bits != 0 && bits == stop_bits) begin
          sclk_i = pol;
          wait_clk(H);
          if (use_reset) begin
            rst_i = 1'b1;
            wait_clk(1);
            check("rst_dout", dout_o, 8'h00);
            check("rst_tick", spi_done_tick_o, 1'b0);
            check("rst_busy", busy_o, 1'b0);
            check("rst_miso", miso_o, 1'b0);
            check("rst_oe", miso_oe_o, 1'b0);
            rst_i = 1'b0;
            last_dout = 8'h00;
            wait_clk(3 * H);
            check("ss_low_at_release_busy", busy_o, 1'b0);
            ss_n_i = 1'b1;
            wait_clk(H);
          end else begin
            ss_n_i = 1'b1;
            wait_clk(H);
            check("abort_busy", busy_o, 1'b0);
            check("abort_oe", miso_oe_o, 1'b0);
            check("abort_dout", dout_o, last_dout);
          end
          return;
        end
        bits++;
        if (!pha) begin
          mosi_i = wire_bit(m_tx[b], i);
          wait_clk(H);
          sclk_i = !pol;
          rxm = wire_acc(rxm, miso_o);
        end else begin
          sclk_i = !pol;
          mosi_i = wire_bit(m_tx[b], i);
          wait_clk(H);
          rxm = wire_acc(rxm, miso_o);
          sclk_i = pol;
        end
        if (i == 3) begin
          check("busy_mid", busy_o, 1'b1);
          check("oe_mid", miso_oe_o, 1'b1);
        end
        if (i == 7) begin
          exp_q.push_back(m_tx[b]);
          last_dout = m_tx[b];
          wait_clk(6);
          if (b + 1 < nbytes) din_i = s_din[b+1];
          wait_clk(H - 6);
        end else begin
          wait_clk(H);
        end
        if (!pha) sclk_i = pol;
      end
      check("master_rx", rxm, s_din[b]);
    end
    wait_clk(H);
    ss_n_i = 1'b1;
    wait_clk(H);
    check("end_busy", busy_o, 1'b0);
    check("end_oe", miso_oe_o, 1'b0);
  endtask

  task automatic one(input logic pol, input logic pha, input logic [7:0] m, input logic [7:0] s);
    m_tx[0]  = m;
    s_din[0] = s;
    frame(pol, pha, 1, 0, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1; cpol_i = 1'b0; cpha_i = 1'b0; din_i = 8'h00;
    sclk_i = 1'b0; ss_n_i = 1'b1; mosi_i = 1'b0;
    last_dout = 8'h00;
    wait_clk(3);
    rst_i = 1'b0;
    wait_clk(1);
    check("reset_dout", dout_o, 8'h00);
    check("reset_tick", spi_done_tick_o, 1'b0);
    check("reset_busy", busy_o, 1'b0);
    check("reset_miso", miso_o, 1'b0);
    check("reset_oe", miso_oe_o, 1'b0);
    wait_clk(H);

    one(1'b0, 1'b0, 8'hA5, 8'h3C);
    one(1'b1, 1'b1, 8'h5A, 8'hC3);
    one(1'b0, 1'b1, 8'h5A, 8'hC3);
    one(1'b1, 1'b0, 8'h5A, 8'hC3);

    // back-to-back in mode 1
    m_tx[0] = 8'h12; m_tx[1] = 8'h34;
    s_din[0] = 8'hAB; s_din[1] = 8'hCD;
    frame(1'b0, 1'b1, 2, 0, 1'b0);

    // abort after 4 bits, then a full frame
    m_tx[0] = 8'hFF; s_din[0] = 8'h55;
    frame(1'b0, 1'b0, 1, 4, 1'b0);
    one(1'b0, 1'b0, 8'h81, 8'h7E);

    // reset after 5 bits, then a full frame
    m_tx[0] = 8'h99; s_din[0] = 8'h66;
    frame(1'b1, 1'b1, 1, 5, 1'b1);
    one(1'b0, 1'b0, 8'hF0, 8'h0F);

    // bit-order corner values
    one(1'b0, 1'b0, 8'h01, 8'h80);

    for (int k = 0; k < 12; k++) begin
      int nb;
      nb = $urandom_range(1, 3);
      for (int j = 0; j < nb; j++) begin
        m_tx[j]  = 8'($urandom_range(0, 255));
        s_din[j] = 8'($urandom_range(0, 255));
      end
      frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), nb, 0, 1'b0);
    end

    wait_clk(2 * H);
    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
